sp_ram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port byte-enabled RAM (sp_ram) between NUM_PORTS requesters, e.g. instruction fetch, LSU and debug/DMA.
- Each requester uses a req/gnt/rvalid protocol. The arbiter drives the RAM's en/addr/wdata/we/be and routes the 1-cycle-latency read data back to the requester that was granted.
- It sits directly in front of the sp_ram instance inside the memory subsystem.

---
 rtl/sp_ram_arbiter.sv | 125 ++++++++++++
 tb/tb_sp_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// Purpose : round-robin arbiter sharing one single-port byte-enabled RAM between NUM_PORTS requesters.
// Latency : grant is combinational in the request cycle; rvalid/rdata follow exactly 1 cycle after the grant.
// Backpressure: losers hold req+payload until granted; responses cannot be stalled by the requester.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   req_i / gnt_o                 per-port request / one-hot-or-zero combinational grant
//   addr_i, we_i, be_i, wdata_i   packed per-port payloads, port k at slice [k*W +: W]
//   rvalid_o / rdata_o            per-port response valid, shared read data (pass-through of mem_rdata_i)
//   mem_en_o .. mem_wdata_o       RAM command, driven from the winning port's slices
//   mem_rdata_i                   RAM read data, registered inside the RAM
module sp_ram_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PORTS-1:0]               req_i,
    output logic [NUM_PORTS-1:0]               gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    addr_i,
    input  logic [NUM_PORTS-1:0]               we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_PORTS-1:0]               rvalid_o,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    output logic                               mem_en_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic                               mem_we_o,
    output logic [DATA_WIDTH/8-1:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0]              mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]              mem_rdata_i
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    // One extra bit so prio + offset can exceed NUM_PORTS-1 before the wrap.
    localparam int CND_WIDTH = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] LAST_PORT = PTR_WIDTH'(NUM_PORTS - 1);
    localparam logic [CND_WIDTH-1:0] PORT_CNT  = CND_WIDTH'(NUM_PORTS);

    logic [PTR_WIDTH-1:0] prio_q, prio_d;
    logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

    logic                 win_vld;
    logic [PTR_WIDTH-1:0] win_idx;
    logic [CND_WIDTH-1:0] cand;
    logic [NUM_PORTS-1:0] gnt;

    // Rotating priority scan: offset 0 is prio_q, wrapping modulo NUM_PORTS.
    // The wrap is a subtract rather than bit truncation so non-power-of-2
    // port counts never visit a non-existent port index.
    always_comb begin : arbitrate
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, prio_q} + CND_WIDTH'(i);
            if (cand >= PORT_CNT) begin
                cand = cand - PORT_CNT;
            end
            if (!win_vld && req_i[cand[PTR_WIDTH-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_WIDTH-1:0];
            end
        end
    end

    // Grant is suppressed during reset so nothing is issued to the RAM.
    always_comb begin : grant
        gnt = '0;
        if (win_vld && !rst) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // RAM command mux. win_idx is 0 when nobody requests, so the idle
    // case naturally presents port 0's slices (don't-care with en low).
    always_comb begin : ram_mux
        mem_addr_o  = addr_i[0 +: ADDR_WIDTH];
        mem_we_o    = we_i[0];
        mem_be_o    = be_i[0 +: BE_WIDTH];
        mem_wdata_o = wdata_i[0 +: DATA_WIDTH];
        for (int k = 1; k < NUM_PORTS; k++) begin
            if (win_idx == PTR_WIDTH'(k)) begin
                mem_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                mem_we_o    = we_i[k];
                mem_be_o    = be_i[k*BE_WIDTH +: BE_WIDTH];
                mem_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The winner drops to lowest priority; with no grant the pointer holds.
    always_comb begin : next_state
        prio_d = prio_q;
        if (|gnt) begin
            prio_d = (win_idx == LAST_PORT) ? '0 : win_idx + PTR_WIDTH'(1);
        end
        // Reads and writes both get a response one cycle after the grant.
        rvalid_d = gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q   <= '0;
            rvalid_q <= '0;
        end else begin
            prio_q   <= prio_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o    = gnt;
    assign mem_en_o = (|req_i) & ~rst;
    assign rvalid_o = rvalid_q;
    // The RAM already registers its output, which provides the 1-cycle latency.
    assign rdata_o  = mem_rdata_i;

`ifndef SYNTHESIS
    gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_o));
    gnt_has_req: assert property (@(posedge clk) disable iff (rst) (gnt_o & ~req_i) == '0);
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Purpose : bench for sp_ram_arbiter (3 ports) with a word RAM and a transaction-level reference model.
// Latency : model predicts grant in-cycle and response/data one cycle later.
// Backpressure: stimulus holds req+payload of ungranted ports stable until they win.
module tb_sp_ram_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req, we, gnt_o, rvalid_o;
    logic [N*AW-1:0] addr;
    logic [N*BW-1:0] be;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata_o, mem_wdata_o, ram_q;
    logic            mem_en_o, mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [BW-1:0]   mem_be_o;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sp_ram_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt_o), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(ram_q)
    );

    // Simple registered-output byte-enabled RAM, 64 words.
    function automatic logic [DW-1:0] init_word(int i);
        return (32'h9E3779B9 * i) ^ 32'h5A5A0F0F;
    endfunction

    logic          ram_load;
    logic [DW-1:0] ram [64];
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                ram_q <= ram[mem_addr_o[7:2]];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [64];
    int            m_prio;
    logic [N-1:0]  m_rvalid;
    bit            m_read;
    logic [DW-1:0] m_rdata;
    int            m_win;
    logic [N-1:0]  exp_gnt;
    logic          exp_en;

    function automatic int find_winner();
        for (int off = 0; off < N; off++) begin
            int p;
            p = (m_prio + off) % N;
            if (req[p]) return p;
        end
        return -1;
    endfunction

    task automatic settle();
        #1;
        m_win   = rst ? -1 : find_winner();
        exp_gnt = '0;
        if (m_win >= 0) exp_gnt[m_win] = 1'b1;
        exp_en  = (|req) && !rst;
    endtask

    // Retire this cycle's transaction in the model, then move to the next negedge.
    task automatic advance();
        logic [5:0] wi;
        if (m_win >= 0) begin
            wi      = addr[m_win*AW+2 +: 6];
            m_prio  = (m_win + 1) % N;
            m_read  = !we[m_win];
            m_rdata = ref_mem[wi];
            if (we[m_win])
                for (int b = 0; b < BW; b++)
                    if (be[m_win*BW+b]) ref_mem[wi][8*b +: 8] = wdata[m_win*DW+8*b +: 8];
        end
        m_rvalid = exp_gnt;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_port(int p, bit r, bit w, logic [AW-1:0] a, logic [BW-1:0] b, logic [DW-1:0] d);
        req[p]            = r;
        we[p]             = w;
        addr[p*AW +: AW]  = a;
        be[p*BW +: BW]    = b;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_prio   = 0;
        m_rvalid = '0;
        m_read   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        ram_load = 1'b1;
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, AW'(p*4), 4'hF, '0);
        #3;
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt_o); end
        checks++; if (mem_en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", mem_en_o); end
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b want 000", rvalid_o); end
        checks++; if (int'(dut.prio_q) !== 0) begin errors++; $display("FAIL reset_prio: got %0d want 0", dut.prio_q); end
        @(posedge clk); @(posedge clk); #1;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL reset_rvalid_held: got %b want 000", rvalid_o); end
        @(negedge clk);
        rst = 1'b0;
        ram_load = 1'b0;
        req = '0;
        model_reset();
    endtask

    task automatic test_single_port();
        set_port(0, 1'b1, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        settle();
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL single_wr_gnt: got %b want 001", gnt_o); end
        advance();
        set_port(0, 1'b1, 1'b0, 8'h10, 4'h0, '0);
        settle();
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL single_rd_gnt: got %b want 001", gnt_o); end
        checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL single_wr_rvalid: got %b want 001", rvalid_o); end
        advance();
        req = '0;
        settle();
        checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL single_rd_rvalid: got %b want 001", rvalid_o); end
        checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata_o); end
        checks++; if (int'(dut.prio_q) !== 1) begin errors++; $display("FAIL single_prio: got %0d want 1", dut.prio_q); end
        advance();
    endtask

    task automatic test_contention();
        logic [N-1:0] want;
        do_reset();
        set_port(0, 1'b1, 1'b0, AW'($urandom_range(0, 255)), 4'h0, '0);
        set_port(1, 1'b1, 1'b0, AW'($urandom_range(0, 255)), 4'h0, '0);
        for (int c = 0; c < 6; c++) begin
            settle();
            want = (c % 2 == 0) ? 3'b001 : 3'b010;
            checks++; if (gnt_o !== want) begin errors++; $display("FAIL contention_gnt[%0d]: got %b want %b", c, gnt_o, want); end
            checks++; if (rvalid_o !== m_rvalid) begin errors++; $display("FAIL contention_rvalid[%0d]: got %b want %b", c, rvalid_o, m_rvalid); end
            if (m_rvalid != 0 && m_read) begin
                checks++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL contention_rdata[%0d]: got %h want %h", c, rdata_o, m_rdata); end
            end
            advance();
        end
        req = '0;
        settle();
        checks++; if (rvalid_o !== 3'b010) begin errors++; $display("FAIL contention_last_rvalid: got %b want 010", rvalid_o); end
        advance();
    endtask

    task automatic test_byte_enable();
        req = '0;
        set_port(1, 1'b1, 1'b1, 8'h20, 4'hF, 32'hAAAAAAAA);
        settle();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL be_prefill_gnt: got %b want 010", gnt_o); end
        advance();
        set_port(1, 1'b1, 1'b1, 8'h20, 4'b0101, 32'h11223344);
        settle();
        checks++; if (mem_be_o !== 4'b0101 || mem_we_o !== 1'b1 || mem_addr_o !== 8'h20)
            begin errors++; $display("FAIL be_cmd: got be=%b we=%b addr=%h want be=0101 we=1 addr=20", mem_be_o, mem_we_o, mem_addr_o); end
        advance();
        set_port(1, 1'b1, 1'b0, 8'h20, 4'h0, '0);
        settle();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL be_rd_gnt: got %b want 010", gnt_o); end
        advance();
        req = '0;
        settle();
        checks++; if (rdata_o !== 32'hAA22AA44) begin errors++; $display("FAIL be_rdata: got %h want aa22aa44", rdata_o); end
        advance();
    endtask

    task automatic test_wrap();
        logic [N-1:0] want;
        do_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, AW'($urandom_range(0, 255)), 4'h0, '0);
        for (int c = 0; c < 6; c++) begin
            settle();
            want = '0;
            want[c % N] = 1'b1;
            checks++; if (gnt_o !== want) begin errors++; $display("FAIL wrap_gnt[%0d]: got %b want %b", c, gnt_o, want); end
            checks++; if (rvalid_o !== m_rvalid) begin errors++; $display("FAIL wrap_rvalid[%0d]: got %b want %b", c, rvalid_o, m_rvalid); end
            advance();
        end
        req = 3'b010;
        settle();
        checks++; if (gnt_o !== 3'b010) begin errors++; $display("FAIL wrap_p1_gnt: got %b want 010", gnt_o); end
        advance();
        req = 3'b100;
        settle();
        checks++; if (gnt_o !== 3'b100) begin errors++; $display("FAIL wrap_p2_gnt: got %b want 100", gnt_o); end
        advance();
        req = '0;
        settle();
        checks++; if (int'(dut.prio_q) !== 0) begin errors++; $display("FAIL wrap_prio: got %0d want 0", dut.prio_q); end
        advance();
    endtask

    task automatic test_reset_mid();
        req = '0;
        set_port(0, 1'b1, 1'b0, 8'h10, 4'h0, '0);
        settle();
        checks++; if (gnt_o !== 3'b001) begin errors++; $display("FAIL rstmid_gnt: got %b want 001", gnt_o); end
        @(posedge clk); #1;
        checks++; if (rvalid_o !== 3'b001) begin errors++; $display("FAIL rstmid_rvalid_pre: got %b want 001", rvalid_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL rstmid_rvalid_drop: got %b want 000", rvalid_o); end
        checks++; if (gnt_o !== 3'b000) begin errors++; $display("FAIL rstmid_gnt_forced: got %b want 000", gnt_o); end
        req = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++; if (rvalid_o !== 3'b000) begin errors++; $display("FAIL rstmid_rvalid_post[%0d]: got %b want 000", c, rvalid_o); end
            checks++; if (int'(dut.prio_q) !== 0) begin errors++; $display("FAIL rstmid_prio[%0d]: got %0d want 0", c, dut.prio_q); end
            advance();
        end
    endtask

    task automatic test_idle();
        int p0;
        set_port(1, 1'b1, 1'b0, 8'h44, 4'h0, '0);
        settle();
        advance();
        p0 = m_prio;
        req = '0;
        for (int c = 0; c < 10; c++) begin
            settle();
            checks++; if (mem_en_o !== 1'b0 || gnt_o !== 3'b000)
                begin errors++; $display("FAIL idle_en_gnt[%0d]: got en=%b gnt=%b want en=0 gnt=000", c, mem_en_o, gnt_o); end
            checks++; if (rvalid_o !== m_rvalid) begin errors++; $display("FAIL idle_rvalid[%0d]: got %b want %b", c, rvalid_o, m_rvalid); end
            checks++; if (int'(dut.prio_q) !== p0) begin errors++; $display("FAIL idle_prio[%0d]: got %0d want %0d", c, dut.prio_q, p0); end
            advance();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] hold;
        hold = '0;
        req  = '0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++)
                if (!hold[p])
                    set_port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                             AW'($urandom_range(0, 255)), BW'($urandom_range(0, 15)), DW'($urandom));
            settle();
            checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt_o, exp_gnt); end
            checks++; if (mem_en_o !== exp_en) begin errors++; $display("FAIL rand_en[%0d]: got %b want %b", c, mem_en_o, exp_en); end
            checks++; if (rvalid_o !== m_rvalid) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b want %b", c, rvalid_o, m_rvalid); end
            checks++; if (int'(dut.prio_q) !== m_prio) begin errors++; $display("FAIL rand_prio[%0d]: got %0d want %0d", c, dut.prio_q, m_prio); end
            if (m_rvalid != 0 && m_read) begin
                checks++; if (rdata_o !== m_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", c, rdata_o, m_rdata); end
            end
            if (m_win >= 0) begin
                checks++;
                if (mem_addr_o !== addr[m_win*AW +: AW] || mem_we_o !== we[m_win] || mem_be_o !== be[m_win*BW +: BW]
                    || (we[m_win] && mem_wdata_o !== wdata[m_win*DW +: DW])) begin
                    errors++;
                    $display("FAIL rand_cmd[%0d]: got addr=%h we=%b be=%b wd=%h want port %0d addr=%h we=%b be=%b wd=%h",
                             c, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, m_win,
                             addr[m_win*AW +: AW], we[m_win], be[m_win*BW +: BW], wdata[m_win*DW +: DW]);
                end
            end
            hold = req & ~exp_gnt;
            advance();
        end
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_reset();
        m_win = -1;
        exp_gnt = '0;
        exp_en = 1'b0;
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        test_reset();
        test_single_port();
        test_contention();
        test_byte_enable();
        test_wrap();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
